// File: rtl/exu_alu_seq.sv
// exu_alu_seq: execution-unit ALU core with a registered result.
// Add/sub/logic/compare complete in one cycle. Shifts walk the operand
// one bit per cycle. valid/ready handshakes on both sides let the EXU
// control stall while a shift is in progress.

`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif
`ifndef ALU_FUNCT_WIDTH
`define ALU_FUNCT_WIDTH 4
`endif
`ifndef NO_FUNCT
`define NO_FUNCT     4'd0
`define ADD          4'd1
`define SUB          4'd2
`define EQ           4'd3
`define NEQ          4'd4
`define LESS         4'd5
`define GREATER_EQ   4'd6
`define LESS_U       4'd7
`define GREATER_EQ_U 4'd8
`define XOR          4'd9
`define OR           4'd10
`define AND          4'd11
`define SHIFT_L_L    4'd12
`define SHIFT_R_L    4'd13
`define SHIFT_R_A    4'd14
`endif

module exu_alu_seq #(
    parameter int WIDTH       = `ISA_WIDTH,
    parameter int FUNCT_WIDTH = `ALU_FUNCT_WIDTH,
    parameter int SHAMT_BITS  = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       alu_a,
    input  logic [WIDTH-1:0]       alu_b,
    input  logic [FUNCT_WIDTH-1:0] alu_funct,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       alu_result,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic [WIDTH-1:0]       work_q, work_d;
    logic [SHAMT_BITS-1:0]  cnt_q, cnt_d;
    logic [FUNCT_WIDTH-1:0] sop_q, sop_d;

    logic [WIDTH-1:0]       op_result;
    logic [WIDTH-1:0]       work_shifted;
    logic [SHAMT_BITS-1:0]  shamt;
    logic                   is_shift;
    logic                   accept;

    assign shamt      = alu_b[SHAMT_BITS-1:0];
    assign in_ready   = (state_q == IDLE) && !rst;
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q == SHIFT);
    assign alu_result = result_q;

    // Single-cycle result; a shift reaching here has shamt=0 and passes alu_a through.
    always_comb begin
        op_result = '0;
        is_shift  = 1'b0;
        case (alu_funct)
            `ADD:          op_result = alu_a + alu_b;
            `SUB:          op_result = alu_a - alu_b;
            `EQ:           op_result = {{(WIDTH-1){1'b0}}, (alu_a == alu_b)};
            `NEQ:          op_result = {{(WIDTH-1){1'b0}}, (alu_a != alu_b)};
            `LESS:         op_result = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            `GREATER_EQ:   op_result = {{(WIDTH-1){1'b0}}, ($signed(alu_a) >= $signed(alu_b))};
            `LESS_U:       op_result = {{(WIDTH-1){1'b0}}, (alu_a < alu_b)};
            `GREATER_EQ_U: op_result = {{(WIDTH-1){1'b0}}, (alu_a >= alu_b)};
            `XOR:          op_result = alu_a ^ alu_b;
            `OR:           op_result = alu_a | alu_b;
            `AND:          op_result = alu_a & alu_b;
            `SHIFT_L_L, `SHIFT_R_L, `SHIFT_R_A: begin
                op_result = alu_a;
                is_shift  = 1'b1;
            end
            default:       op_result = '0;
        endcase
    end

    // One-bit step of the latched shift kind applied to the working register.
    always_comb begin
        work_shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        case (sop_q)
            `SHIFT_L_L: work_shifted = {work_q[WIDTH-2:0], 1'b0};
            `SHIFT_R_L: work_shifted = {1'b0, work_q[WIDTH-1:1]};
            default:    work_shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        endcase
    end

    // Next-state and datapath updates for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        sop_d    = sop_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_shift && (shamt != '0)) begin
                        work_d  = alu_a;
                        cnt_d   = shamt;
                        sop_d   = alu_funct;
                        state_d = SHIFT;
                    end else begin
                        result_d = op_result;
                        state_d  = DONE;
                    end
                end
            end
            SHIFT: begin
                work_d = work_shifted;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == {{(SHAMT_BITS-1){1'b0}}, 1'b1}) begin
                    result_d = work_shifted;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any op in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            sop_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            sop_q    <= sop_d;
        end
    end

endmodule
